// File: rtl/wb_pkg.sv
// Shared widths, write-back source codes, load funct3 codes and state encoding for the write-back stage.
package wb_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RADDR_W  = 5;
  localparam int unsigned WB_SEL_W = 2;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned CNT_W    = 32;

  localparam logic [WB_SEL_W-1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [WB_SEL_W-1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [WB_SEL_W-1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [WB_SEL_W-1:0] WB_SEL_IMM  = 2'b11;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_COMMIT    = 2'd2
  } wb_state_e;

  // One buffered MEM/WB instruction.
  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [RADDR_W-1:0]  rd;
    logic                reg_write;
    logic [WB_SEL_W-1:0] wb_sel;
    logic [XLEN-1:0]     alu_result;
    logic [XLEN-1:0]     imm32;
    logic [F3_W-1:0]     funct3;
  } wb_entry_t;

  // Write-back source mux; PC+4 wraps naturally at XLEN bits.
  function automatic logic [XLEN-1:0] wb_select(
    input logic [WB_SEL_W-1:0] sel,
    input logic [XLEN-1:0]     pc,
    input logic [XLEN-1:0]     alu,
    input logic [XLEN-1:0]     imm,
    input logic [XLEN-1:0]     ld
  );
    logic [XLEN-1:0] res;
    case (sel)
      WB_SEL_LOAD: res = ld;
      WB_SEL_PC4:  res = pc + XLEN'(4);
      WB_SEL_IMM:  res = imm;
      default:     res = alu;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Picks the addressed byte/half of a loaded word and sign- or zero-extends it.
module wb_load_align
  import wb_pkg::*;
(
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      addr_lo,
  input  logic [F3_W-1:0] funct3,
  output logic [XLEN-1:0] data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane extraction then extension by load type; unknown funct3 behaves as LW.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
    case (addr_lo)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    case (funct3)
      F3_LB:   data_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_c = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data_c = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_c = {{(XLEN-16){1'b0}}, half_sel};
      default: data_c = raw;
    endcase
  end

endmodule

// File: rtl/wb_commit_stage.sv
// One-entry MEM/WB buffer driving the register-file write port, forwarding tap and retire counter.
module wb_commit_stage
  import wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [RADDR_W-1:0]  in_rd,
  input  logic                in_reg_write,
  input  logic [WB_SEL_W-1:0] in_wb_sel,
  input  logic [XLEN-1:0]     in_alu_result,
  input  logic [XLEN-1:0]     in_imm32,
  input  logic [F3_W-1:0]     in_funct3,
  input  logic                flush,
  input  logic                dmem_rsp_valid,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic                reg_write,
  output logic [RADDR_W-1:0]  reg_rd,
  output logic [XLEN-1:0]     reg_wdata,
  output logic                fwd_valid,
  output logic [RADDR_W-1:0]  fwd_rd,
  output logic [XLEN-1:0]     fwd_data,
  output logic [CNT_W-1:0]    instret
);

  wb_state_e          state_q, state_d;
  wb_entry_t          entry_q, entry_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               reg_write_q, reg_write_d;
  logic [RADDR_W-1:0] reg_rd_q, reg_rd_d;
  logic [XLEN-1:0]    reg_wdata_q, reg_wdata_d;
  logic [XLEN-1:0]    load_data;
  logic               accept;

  wb_load_align u_align (
    .raw     (dmem_rdata),
    .addr_lo (entry_q.alu_result[1:0]),
    .funct3  (entry_q.funct3),
    .data_c  (load_data)
  );

  assign in_ready = rst & ~flush & ((state_q == ST_IDLE) | (state_q == ST_COMMIT));
  assign accept   = in_valid & in_ready;

  // Next-state, entry latch, drop flag, retire count and write-port values.
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    drop_d      = drop_q;
    instret_d   = instret_q;
    reg_write_d = 1'b0;
    reg_rd_d    = reg_rd_q;
    reg_wdata_d = reg_wdata_q;

    case (state_q)
      ST_IDLE: ;
      ST_WAIT_LOAD: begin
        if (flush) drop_d = 1'b1;
        if (dmem_rsp_valid) begin
          if (drop_q | flush) begin
            state_d = ST_IDLE;
            drop_d  = 1'b0;
          end else begin
            state_d = ST_COMMIT;
            if (entry_q.reg_write && (entry_q.rd != '0)) begin
              reg_write_d = 1'b1;
              reg_rd_d    = entry_q.rd;
              reg_wdata_d = wb_select(entry_q.wb_sel, entry_q.pc, entry_q.alu_result,
                                      entry_q.imm32, load_data);
            end
          end
        end
      end
      ST_COMMIT: begin
        instret_d = instret_q + CNT_W'(1);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept is only possible from IDLE or COMMIT, so it overrides their next state.
    if (accept) begin
      entry_d = '{pc: in_pc, rd: in_rd, reg_write: in_reg_write, wb_sel: in_wb_sel,
                  alu_result: in_alu_result, imm32: in_imm32, funct3: in_funct3};
      if (in_wb_sel == WB_SEL_LOAD) begin
        state_d = ST_WAIT_LOAD;
      end else begin
        state_d = ST_COMMIT;
        if (in_reg_write && (in_rd != '0)) begin
          reg_write_d = 1'b1;
          reg_rd_d    = in_rd;
          reg_wdata_d = wb_select(in_wb_sel, in_pc, in_alu_result, in_imm32, load_data);
        end
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      entry_q     <= '0;
      drop_q      <= 1'b0;
      instret_q   <= '0;
      reg_write_q <= 1'b0;
      reg_rd_q    <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      drop_q      <= drop_d;
      instret_q   <= instret_d;
      reg_write_q <= reg_write_d;
      reg_rd_q    <= reg_rd_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  assign reg_write = reg_write_q;
  assign reg_rd    = reg_rd_q;
  assign reg_wdata = reg_wdata_q;
  assign fwd_valid = reg_write_q;
  assign fwd_rd    = reg_rd_q;
  assign fwd_data  = reg_wdata_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed scoreboard bench for wb_commit_stage.
module tb_wb_commit_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_imm32;
  logic [2:0]  in_funct3;
  logic        flush;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        reg_write;
  logic [4:0]  reg_rd;
  logic [31:0] reg_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [31:0] instret;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_instret = 0;

  always #5 clk = ~clk;

  wb_commit_stage dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_rd          (in_rd),
    .in_reg_write   (in_reg_write),
    .in_wb_sel      (in_wb_sel),
    .in_alu_result  (in_alu_result),
    .in_imm32       (in_imm32),
    .in_funct3      (in_funct3),
    .flush          (flush),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata),
    .reg_write      (reg_write),
    .reg_rd         (reg_rd),
    .reg_wdata      (reg_wdata),
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data),
    .instret        (instret)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Every write pulse must match the oldest expected write.
  task automatic check_outputs();
    exp_t e;
    if (reg_write === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", 32'(reg_write), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("wr_rd", 32'(reg_rd), 32'(e.rd));
        chk("wr_data", reg_wdata, e.data);
        chk("fwd_valid", 32'(fwd_valid), 32'd1);
        chk("fwd_rd", 32'(fwd_rd), 32'(e.rd));
        chk("fwd_data", fwd_data, e.data);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive_instr(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                             input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3);
    in_valid      = 1'b1;
    in_rd         = rd;
    in_reg_write  = 1'b1;
    in_wb_sel     = sel;
    in_alu_result = alu;
    in_pc         = pc;
    in_imm32      = imm;
    in_funct3     = f3;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Load with a response after 'gap' idle cycles; expects exp_data to be written to rd.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp_data, input int gap);
    drive_instr(rd, 2'b01, addr, 32'h100, 32'h0, f3);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      chk("load_wait_ready", 32'(in_ready), 32'd0);
      chk("load_wait_nowrite", 32'(reg_write), 32'd0);
      tick();
    end
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = rdata;
    push(rd, exp_data);
    tick();
    chk("load_wr_pulse", 32'(reg_write), 32'd1);
    dmem_rsp_valid = 1'b0;
    tick();
    exp_instret++;
    chk("load_instret", instret, exp_instret);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_rd = '0; in_reg_write = 1'b0;
    in_wb_sel = '0; in_alu_result = '0; in_imm32 = '0; in_funct3 = '0;
    flush = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;

    // Reset
    tick(); tick();
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wdata", reg_wdata, 32'd0);
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back ALU
    drive_instr(5'd5, 2'b00, 32'h11, 32'h0, 32'h0, 3'b000);
    push(5'd5, 32'h11);
    tick();
    chk("b2b_pulse1", 32'(reg_write), 32'd1);
    chk("b2b_ready_in_commit", 32'(in_ready), 32'd1);
    drive_instr(5'd6, 2'b00, 32'h22, 32'h0, 32'h0, 3'b000);
    push(5'd6, 32'h22);
    tick();
    chk("b2b_pulse2", 32'(reg_write), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("b2b_pulse_end", 32'(reg_write), 32'd0);
    exp_instret = 32'd2;
    chk("b2b_instret", instret, exp_instret);

    // Load alignment
    do_load(5'd7, 3'b000, 32'h0000_1003, 32'h80FF_FF01, 32'hFFFF_FF80, 0);
    do_load(5'd8, 3'b101, 32'h0000_1002, 32'h80FF_FF01, 32'h0000_80FF, 3);
    do_load(5'd11, 3'b001, 32'h0000_2003, 32'h8001_1234, 32'hFFFF_8001, 1);
    do_load(5'd12, 3'b100, 32'h0000_2001, 32'h0000_9A00, 32'h0000_009A, 0);
    do_load(5'd13, 3'b010, 32'h0000_2000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    do_load(5'd14, 3'b111, 32'h0000_2002, 32'hCAFE_F00D, 32'hCAFE_F00D, 0);

    // Flush during load wait drops the response
    drive_instr(5'd9, 2'b01, 32'h0000_3000, 32'h0, 32'h0, 3'b010);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 32'h1234_5678;
    tick();
    chk("flush_no_write", 32'(reg_write), 32'd0);
    dmem_rsp_valid = 1'b0;
    chk("flush_ready_after", 32'(in_ready), 32'd1);
    tick();
    chk("flush_instret", instret, exp_instret);
    drive_instr(5'd10, 2'b00, 32'h33, 32'h0, 32'h0, 3'b000);
    push(5'd10, 32'h33);
    tick();
    chk("post_flush_write", 32'(reg_write), 32'd1);
    in_valid = 1'b0;
    tick();
    exp_instret++;
    chk("post_flush_instret", instret, exp_instret);

    // rd=0 commit: counted, no write, outputs hold
    drive_instr(5'd0, 2'b00, 32'h55, 32'h0, 32'h0, 3'b000);
    tick();
    chk("rd0_no_write", 32'(reg_write), 32'd0);
    chk("rd0_hold_rd", 32'(reg_rd), 32'd10);
    chk("rd0_hold_data", reg_wdata, 32'h33);
    in_valid = 1'b0;
    tick();
    exp_instret++;
    chk("rd0_instret", instret, exp_instret);

    // JAL PC+4 wrap and LUI immediate back-to-back
    drive_instr(5'd1, 2'b10, 32'h0, 32'hFFFF_FFFC, 32'h0, 3'b000);
    push(5'd1, 32'h0000_0000);
    tick();
    drive_instr(5'd2, 2'b11, 32'h0, 32'h0, 32'hABCD_E000, 3'b000);
    push(5'd2, 32'hABCD_E000);
    tick();
    in_valid = 1'b0;
    tick();
    exp_instret += 2;
    chk("jal_lui_instret", instret, exp_instret);

    // Flush during COMMIT blocks the same-cycle accept
    drive_instr(5'd3, 2'b00, 32'h44, 32'h0, 32'h0, 3'b000);
    push(5'd3, 32'h44);
    tick();
    drive_instr(5'd4, 2'b00, 32'h66, 32'h0, 32'h0, 3'b000);
    flush = 1'b1;
    #1;
    chk("commit_flush_ready", 32'(in_ready), 32'd0);
    tick();
    chk("commit_flush_no_accept", 32'(reg_write), 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("commit_flush_no_write2", 32'(reg_write), 32'd0);
    exp_instret++;
    chk("commit_flush_instret", instret, exp_instret);

    // Stray response outside WAIT_LOAD is ignored
    dmem_rsp_valid = 1'b1;
    tick();
    dmem_rsp_valid = 1'b0;
    tick();
    chk("stray_rsp_instret", instret, exp_instret);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
